// File: rtl/tdc_readout_arb.sv
// -----------------------------------------------------------------------------
// tdc_readout_arb
//
// Collects finished measurements from NCH TDC channels and serialises them
// onto a single valid/ready output stream.
//
// Each channel has a one-entry holding register and a pending bit. A capture
// is accepted only if the word carries the 4'b0101 marker in its low nibble.
// Bad-marker words are counted in err_cnt. A good word that arrives while the
// slot is still occupied sets the sticky ovf flag and is discarded. A
// two-state FSM grants pending channels round-robin. Each grant holds the
// output until the downstream side accepts it.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   ch_valid   : [NCH]     one-cycle capture pulse per channel
//   ch_data    : [40*NCH]  measurement words, channel k at [40k+39:40k]
//   cfg_en     : [NCH]     per-channel enable; disabled channels lose pending
//   cfg_clr    : clears ovf and err_cnt (wins over a same-edge set/increment)
//   out_ready  : downstream ready
//   out_valid  : output word valid
//   out_data   : [40+CW]   {channel id, stored 40-bit word}
//   ovf        : [NCH]     sticky per-channel overflow flags
//   err_cnt    : [8]       saturating bad-marker counter
//   word_cnt   : [16]      wrapping count of delivered words
// -----------------------------------------------------------------------------
module tdc_readout_arb #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [40*NCH-1:0] ch_data,
  input  logic [NCH-1:0]    cfg_en,
  input  logic              cfg_clr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [40+CW-1:0]  out_data,
  output logic [NCH-1:0]    ovf,
  output logic [7:0]        err_cnt,
  output logic [15:0]       word_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [3:0] MARKER = 4'b0101;

  logic [0:0]     state;
  logic [NCH-1:0] pending;
  logic [39:0]    hold [NCH];
  logic [CW-1:0]  last_ptr;

  // Arbitration results for the current edge.
  logic           grant_vld;
  logic [CW-1:0]  grant_idx;
  logic [NCH-1:0] req;
  int             cand;

  // Per-channel capture decode.
  logic [NCH-1:0] store;
  logic [NCH-1:0] ovf_set;
  logic [NCH-1:0] pending_nxt;
  logic [3:0]     bad_cnt;
  logic [8:0]     err_sum;
  logic [7:0]     err_nxt;

  // Round-robin search: start one past the last grant and wrap to 0.
  // Disabled channels are masked so a word is never delivered from a
  // channel that is being switched off on this edge.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    req       = pending & cfg_en;
    if (state == S_IDLE) begin
      for (int i = 1; i <= NCH; i++) begin
        cand = (int'(last_ptr) + i) % NCH;
        if (!grant_vld && req[cand]) begin
          grant_vld = 1'b1;
          grant_idx = CW'(cand);
        end
      end
    end
  end

  // Capture classification. A good word is stored when the slot is free
  // or is being emptied by a grant on this same edge; otherwise it
  // overflows. Bad-marker words never touch the slot.
  always_comb begin
    store       = '0;
    ovf_set     = '0;
    pending_nxt = pending;
    bad_cnt     = '0;
    for (int k = 0; k < NCH; k++) begin
      logic cap;
      logic good;
      logic granted;
      cap     = ch_valid[k] && cfg_en[k];
      good    = cap && (ch_data[40*k +: 4] == MARKER);
      granted = grant_vld && (grant_idx == CW'(k));
      if (cap && !good) begin
        bad_cnt = bad_cnt + 4'd1;
      end
      store[k]   = good && (!pending[k] || granted);
      ovf_set[k] = good && pending[k] && !granted;
      if (!cfg_en[k]) begin
        pending_nxt[k] = 1'b0;
      end else if (store[k]) begin
        pending_nxt[k] = 1'b1;
      end else if (granted) begin
        pending_nxt[k] = 1'b0;
      end
    end
    err_sum = {1'b0, err_cnt} + 9'(bad_cnt);
    if (cfg_clr) begin
      err_nxt = 8'd0;
    end else if (err_sum > 9'd255) begin
      err_nxt = 8'hFF;
    end else begin
      err_nxt = err_sum[7:0];
    end
  end

  // Holding registers and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the holding array is small and must read as zero after
      // reset, so it sits in the reset branch like ordinary flops.
      for (int k = 0; k < NCH; k++) begin
        hold[k] <= '0;
      end
      pending <= '0;
      ovf     <= '0;
      err_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed above.
      for (int k = 0; k < NCH; k++) begin
        if (store[k]) begin
          hold[k] <= ch_data[40*k +: 40];
        end
      end
      pending <= pending_nxt;
      ovf     <= cfg_clr ? '0 : (ovf | ovf_set);
      err_cnt <= err_nxt;
    end
  end

  // Output FSM. out_data is loaded only on a grant, so it is stable for
  // the whole SEND phase regardless of out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
      last_ptr  <= CW'(NCH - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= {grant_idx, hold[grant_idx]};
            last_ptr  <= grant_idx;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            word_cnt  <= word_cnt + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_readout_arb.sv
// -----------------------------------------------------------------------------
// tb_tdc_readout_arb
//
// Directed bench for tdc_readout_arb (NCH=4, CW=2). Inputs change 1 ns after
// a rising edge, and outputs are read at that same point. Each read therefore
// shows the state left by the edge just taken. Expected values are written
// out by hand for each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tdc_readout_arb;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    ch_valid;
  logic [40*NCH-1:0] ch_data;
  logic [NCH-1:0]    cfg_en;
  logic              cfg_clr;
  logic              out_ready;
  logic              out_valid;
  logic [40+CW-1:0]  out_data;
  logic [NCH-1:0]    ovf;
  logic [7:0]        err_cnt;
  logic [15:0]       word_cnt;

  int checks   = 0;
  int failures = 0;

  tdc_readout_arb #(.NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .cfg_en    (cfg_en),
    .cfg_clr   (cfg_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ovf       (ovf),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [39:0] w);
    ch_data[40*k +: 40] = w;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  logic [39:0] wa, wb, wc, w3;
  int          seen;

  initial begin
    reset     = 1'b0;
    ch_valid  = '0;
    ch_data   = '0;
    cfg_en    = '1;
    cfg_clr   = 1'b0;
    out_ready = 1'b1;

    // ---------------- reset state ----------------
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_err_cnt",   64'(err_cnt),   64'd0);
    check("rst_word_cnt",  64'(word_cnt),  64'd0);
    reset = 1'b1;
    step();

    // ---------------- single word, channel 2 ----------------
    set_word(2, 40'h1234567895);
    ch_valid = 4'b0100;
    step();                                    // capture edge
    ch_valid = '0;
    check("single_not_yet", 64'(out_valid), 64'd0);
    step();                                    // grant edge
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data",  64'(out_data),  64'({2'd2, 40'h1234567895}));
    step();                                    // accepted
    check("single_drop",  64'(out_valid), 64'd0);
    check("single_wcnt",  64'(word_cnt),  64'd1);

    // ---------------- round robin from reset ----------------
    do_reset();
    for (int k = 0; k < NCH; k++) set_word(k, {32'hA0B0C000, k[3:0], 4'h5});
    ch_valid = 4'b1111;
    step();
    ch_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      step();
      check($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("rr_data_%0d", k), 64'(out_data),
            64'({k[1:0], 32'hA0B0C000, k[3:0], 4'h5}));
      step();
      check($sformatf("rr_gap_%0d", k), 64'(out_valid), 64'd0);
    end
    check("rr_wcnt", 64'(word_cnt), 64'd4);
    check("rr_ovf",  64'(ovf),      64'd0);

    // ---------------- overflow and backpressure, channel 1 ----------------
    // A moves to the output and stalls. B refills the freed slot. C finds
    // the slot occupied and is dropped, which flags the overflow.
    do_reset();
    wa = 40'h00000AAAA5;
    wb = 40'h00000BBBB5;
    wc = 40'h00000CCCC5;
    out_ready = 1'b0;
    set_word(1, wa);
    ch_valid  = 4'b0010;
    step();
    ch_valid  = '0;
    step();
    check("bp_valid_a", 64'(out_valid), 64'd1);
    check("bp_data_a",  64'(out_data),  64'({2'd1, wa}));
    step();
    set_word(1, wb);
    ch_valid = 4'b0010;
    step();
    ch_valid = '0;
    step();
    check("bp_hold_a1", 64'(out_data), 64'({2'd1, wa}));
    check("bp_no_ovf",  64'(ovf),      64'd0);
    set_word(1, wc);
    ch_valid = 4'b0010;
    step();
    ch_valid = '0;
    check("bp_ovf_set",  64'(ovf),       64'b0010);
    check("bp_hold_a2",  64'(out_data),  64'({2'd1, wa}));
    check("bp_still_v",  64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_accept_a", 64'(out_valid), 64'd0);
    check("bp_wcnt1",    64'(word_cnt),  64'd1);
    step();
    check("bp_valid_b",  64'(out_valid), 64'd1);
    check("bp_data_b",   64'(out_data),  64'({2'd1, wb}));
    step();
    step();
    check("bp_no_c",     64'(out_valid), 64'd0);
    check("bp_wcnt2",    64'(word_cnt),  64'd2);
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
    check("bp_ovf_clr",  64'(ovf),       64'd0);

    // ---------------- bad marker ----------------
    do_reset();
    set_word(0, 40'h123456789F);
    ch_valid = 4'b0001;
    step();
    ch_valid = '0;
    step();
    check("bad_no_valid", 64'(out_valid), 64'd0);
    check("bad_err1",     64'(err_cnt),   64'd1);
    ch_valid = 4'b0001;
    for (int i = 0; i < 300; i++) step();
    ch_valid = '0;
    check("bad_err_sat",  64'(err_cnt),   64'd255);
    check("bad_no_valid2",64'(out_valid), 64'd0);
    // Clear wins over an increment on the same edge.
    cfg_clr  = 1'b1;
    ch_valid = 4'b0001;
    step();
    cfg_clr  = 1'b0;
    ch_valid = '0;
    check("bad_clr_prio", 64'(err_cnt),   64'd0);

    // ---------------- disabled channel ----------------
    do_reset();
    cfg_en = 4'b0111;
    set_word(3, 40'h3333333335);
    ch_valid = 4'b1000;
    step();
    step();
    ch_valid = '0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("dis_no_out", 64'(seen),     64'd0);
    check("dis_ovf",    64'(ovf),      64'd0);
    check("dis_wcnt",   64'(word_cnt), 64'd0);
    cfg_en = 4'b1111;

    // ---------------- reset mid-operation ----------------
    do_reset();
    out_ready = 1'b0;
    set_word(0, 40'h0000000105);
    set_word(1, 40'h0000000115);
    set_word(2, 40'h0000000125);
    ch_valid = 4'b0111;
    step();
    ch_valid = '0;
    step();
    check("mid_valid_pre", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_valid_async", 64'(out_valid), 64'd0);
    check("mid_data_async",  64'(out_data),  64'd0);
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mid_no_out",  64'(seen),     64'd0);
    check("mid_wcnt",    64'(word_cnt), 64'd0);
    w3 = 40'h0000000335;
    set_word(3, w3);
    ch_valid = 4'b1000;
    step();
    ch_valid = '0;
    step();
    check("mid_new_valid", 64'(out_valid), 64'd1);
    check("mid_new_data",  64'(out_data),  64'({2'd3, w3}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
